// File: rtl/instr_encoder_if.sv
// Beat-level bus for instr_encoder: field-level input beat in, packed instruction word out.
// Both directions use valid/ready; the encoder side is the slave modport.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_format;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport slave (
    input  in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport master (
    output in_valid, in_format, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: checks and scatters the immediate, emits word + sequential address.
// Two-stage pipeline (accept at edge N -> out_valid after N+1); stalls hold output stable, in_ready drops when both stages are full.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  instr_encoder_if.slave    bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic [7:0]        err_count
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Stage-1 state
  logic        s1_valid;
  logic [2:0]  s1_format;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;
  logic        s1_err;

  // Stage-2 state
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic              out_err_q;
  logic [ADDR_W-1:0] addr_cnt;

  logic        s2_accept;
  logic        s1_adv;
  logic        take;
  logic        out_xfer;
  logic        imm_bad;
  logic        chk_err;
  logic [31:0] word;

  assign s2_accept = !out_valid_q || bus.out_ready;
  assign s1_adv    = s1_valid && s2_accept;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign take      = bus.in_valid && bus.in_ready;
  assign out_xfer  = out_valid_q && bus.out_ready;

  // Immediate must be representable in the format's field (sign-extension holds) and aligned where required.
  always_comb begin
    imm_bad = 1'b0;
    case (bus.in_format)
      FMT_R:        imm_bad = 1'b0;
      FMT_I, FMT_S: imm_bad = (bus.in_imm[31:11] != {21{bus.in_imm[11]}});
      FMT_B:        imm_bad = (bus.in_imm[31:12] != {20{bus.in_imm[12]}}) || bus.in_imm[0];
      FMT_U:        imm_bad = (bus.in_imm[11:0] != 12'd0);
      FMT_J:        imm_bad = (bus.in_imm[31:20] != {12{bus.in_imm[20]}}) || bus.in_imm[0];
      default:      imm_bad = 1'b1;
    endcase
    chk_err = imm_bad || (bus.in_opcode[1:0] != 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (take) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Payload registers need no reset: they are only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (take) begin
      s1_format <= bus.in_format;
      s1_opcode <= bus.in_opcode;
      s1_rd     <= bus.in_rd;
      s1_rs1    <= bus.in_rs1;
      s1_rs2    <= bus.in_rs2;
      s1_funct3 <= bus.in_funct3;
      s1_funct7 <= bus.in_funct7;
      s1_imm    <= bus.in_imm;
      s1_err    <= chk_err;
    end
  end

  always_comb begin
    word = NOP;
    case (s1_format)
      FMT_R: word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                     s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
      default: word = NOP;
    endcase
    if (s1_err) begin
      word = NOP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'd0;
      out_err_q   <= 1'b0;
    end else if (s2_accept) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_instr_q <= word;
        out_err_q   <= s1_err;
      end
    end
  end

  // A load takes priority over the post-transfer increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt <= BASE_ADDR;
    end else if (addr_load) begin
      addr_cnt <= addr_value;
    end else if (out_xfer) begin
      addr_cnt <= addr_cnt + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (out_xfer && out_err_q && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_addr  = addr_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: stimulus pushes hand-computed words into a scoreboard,
// an independent monitor pops and compares on every output transfer.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        addr_load;
  logic [31:0] addr_value;
  logic [7:0]  err_count;

  instr_encoder_if #(.ADDR_W(32)) bus ();

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] sb_addr;
  int          tests;
  int          fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    exp_t e;
    bit   accepted;
    bus.in_valid  = 1'b1;
    bus.in_format = fmt;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.instr = exp_instr;
        e.err   = exp_err;
        e.addr  = sb_addr;
        sb.push_back(e);
        sb_addr  = sb_addr + 32'd4;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: beat with expected word %h never accepted", exp_instr);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every output transfer against the scoreboard and checks stall stability.
  initial begin : monitor
    exp_t        e;
    bit          stall;
    logic [31:0] s_instr;
    logic [31:0] s_addr;
    logic        s_err;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_instr", bus.out_instr, s_instr);
        check("stall_addr",  bus.out_addr,  s_addr);
        check("stall_err",   bus.out_err,   s_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h with empty scoreboard", bus.out_instr);
        end else begin
          e = sb.pop_front();
          check("out_instr", bus.out_instr, e.instr);
          check("out_err",   bus.out_err,   e.err);
          check("out_addr",  bus.out_addr,  e.addr);
        end
      end
      stall   = bus.out_valid && !bus.out_ready;
      s_instr = bus.out_instr;
      s_addr  = bus.out_addr;
      s_err   = bus.out_err;
    end
  end

  initial begin
    tests         = 0;
    fails         = 0;
    sb_addr       = 32'h0;
    reset         = 1'b1;
    addr_load     = 1'b0;
    addr_value    = 32'h0;
    bus.in_valid  = 1'b0;
    bus.in_format = 3'd0;
    bus.in_opcode = 7'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_imm    = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_err",   bus.out_err,   0);
    check("rst_err_count", err_count,     0);
    check("rst_out_addr",  bus.out_addr,  32'h0);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1;

    // add x3,x1,x2 with a junk immediate that must be ignored; 2-cycle latency
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
    check("lat_not_yet", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid", bus.out_valid, 1);
    drain();

    // addi x1,x0,-1 then sw x2,8(x1), back-to-back
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0);
    // beq x0,x0,-4 ; jal x1,2048 ; lui x5,0x12345 ; addi x1,x0,-2048 (I-range edge)
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    drain();
    check("err_count_clean", err_count, 0);

    // Illegal beats: each becomes NOP with err, address still consumed
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001, 32'h0000_0013, 1'b1);
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);
    drain();
    check("err_count_4", err_count, 4);
    send(3'd0, 7'h30, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);
    drain();
    check("err_count_5", err_count, 5);

    // Backpressure: out_ready low while 5 addi beats stream in
    bus.out_ready = 1'b0;
    fork
      begin
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
        send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
        send(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0193, 1'b0);
        send(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h0040_0213, 1'b0);
        send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0293, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_valid",    bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // addr_load coincident with an output transfer: load wins, then wrap
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0020_81B3, 1'b0);
    @(posedge clk);
    #1;
    check("load_xfer_valid", bus.out_valid, 1);
    addr_load  = 1'b1;
    addr_value = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    addr_load = 1'b0;
    check("load_counter", bus.out_addr, 32'hFFFF_FFFC);
    sb_addr = 32'hFFFF_FFFC;
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    drain();
    check("wrap_counter", bus.out_addr, 32'h0000_0004);

    // Async reset mid-stream discards in-flight beats
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0);
    check("pre_rst_valid", bus.out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_addr",  bus.out_addr,  32'h0);
    check("mid_rst_err_count", err_count,     0);
    check("mid_rst_in_ready",  bus.in_ready,  1);
    sb.delete();
    sb_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h0020_81B3, 1'b0);
    drain();
    check("final_err_count", err_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined RISC-V RV32I instruction encoder: the inverse of the immediate/field decode path.
- Accepts a format tag, register/function fields and a full 32-bit immediate value.
- Range- and alignment-checks the immediate, scatters it into the format-specific bit positions, and emits the packed 32-bit instruction word with a sequential instruction-memory address.
- Used by the program loader and self-test sequencer to write instruction memory.

Parameters:
- ADDR_W, 32, width of the output address counter.
- BASE_ADDR, 32'h0000_0000, reset/initial value of the address counter.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder can accept a beat
- in_format  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  in  7  opcode field, passed through
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  immediate as a signed/absolute value (U: full value with low 12 bits zero)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  address for out_instr
- out_err  out  1  word was illegal and replaced by NOP
- err_count  out  8  saturating count of errored words delivered
- addr_load  in  1  load address counter
- addr_value  in  ADDR_W  value for addr_load

Behaviour:
- Reset (async, immediate): out_valid=0, out_instr=0, out_err=0, err_count=0, address counter=BASE_ADDR, stage-1 valid=0. in_ready=1 after reset.
- Pipeline: stage 1 registers the inputs and the check result; stage 2 registers the encoded word.
  - A beat accepted at edge N gives out_valid=1 after edge N+1 (2-cycle latency).
  - Full throughput of 1 beat/cycle with out_ready held high.
- Handshake:
  - s2_accept = !out_valid || out_ready
  - s1_adv = s1_valid && s2_accept
  - in_ready = !s1_valid || s1_adv (combinational)
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_instr, out_addr and out_err stay stable while out_valid && !out_ready.
  - No beat is ever dropped or duplicated.
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - in_imm is ignored for R.
- Checks (any failure gives err):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - Format 6/7 is illegal.
  - in_opcode[1:0]!=2'b11 is illegal.
- On err: out_instr=32'h0000_0013 (NOP), out_err=1; the address is still consumed.
- Address:
  - out_addr = counter value.
  - Counter += 4 on each output transfer, wrapping modulo 2^ADDR_W.
  - addr_load sets counter=addr_value next edge; if coincident with an output transfer, the load wins.
  - addr_load does not flush the pipeline.
- err_count: +1 on each output transfer with out_err=1; saturates at 255.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted afterward until new input.

Test Plan:
- R add x3,x1,x2 (opcode 0110011, f3=0, f7=0) -> out_instr=0x002081B3, out_addr=0x0, out_err=0, 2 cycles after accept.
- I addi x1,x0,-1, then S sw x2,8(x1) back-to-back -> 0xFFF00093 @0x0, then 0x0020A423 @0x4 on consecutive cycles.
- B beq x0,x0,imm=-4 -> 0xFE000EE3; J jal x1,imm=2048 -> 0x001000EF; U lui x5,imm=0x12345000 -> 0x123452B7.
- Illegal cases: I imm=2048, B imm=3, U imm=0x1001, format=7 -> each emits 0x00000013 with out_err=1; err_count=4; addresses still increment.
- Backpressure: stream 5 beats with out_ready low for 3 cycles -> in_ready drops after 2 beats held; output is stable; all 5 words delivered in order at consecutive addresses.
- addr_load=1, addr_value=0xFFFF_FFFC coincident with an output transfer -> counter=0xFFFF_FFFC; next word is at 0xFFFF_FFFC, the following word wraps to 0x0. Async reset asserted mid-stream -> out_valid=0 immediately, counter=BASE_ADDR.
